// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the instruction fetch stage.
//   ADDR_W / INSTR_W   : program address and instruction word widths
//   FIFO_DEPTH_DEFAULT : default output buffer depth (power of 2, >= 2)
//   OPC_HALT           : opcode in bits [15:12] that stops fetch when halt
//                        detection is built in
//   fetch_state_t      : fetch FSM states
//   fetch_entry_t      : one buffered instruction with the address it came from
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W             = 8;
  localparam int INSTR_W            = 16;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // True when the word carries the halt opcode in its top nibble.
  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Bus bundle around the fetch stage: program-memory read port, redirect
//   input and the valid/ready instruction stream to the decoder.
//   master : the fetch stage (drives imem_rd_en/imem_addr and the instr_* stream)
//   slave  : the environment (program memory, branch unit, decoder)
// -----------------------------------------------------------------------------
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  logic               halted;

  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    output halted
  );

  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    input  halted
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO of fetch_entry_t used as the fetch output buffer.
//   Ports:
//     clk, rst   : clock, synchronous active-low reset (empties the FIFO)
//     push       : write push_data at the tail
//     push_data  : entry to write
//     pop        : drop the head entry (caller only pops when count != 0)
//     flush      : empty the FIFO; wins over push and pop in the same cycle
//     head       : entry at the head (meaningful only when count != 0)
//     count      : current occupancy, 0..DEPTH
//   The caller guarantees no push while full.
// -----------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-2 depth lets the pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which slots hold live data.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage: walks a PC through the 256x16 program image, issues reads to a
//   synchronous 1-cycle program memory and buffers the returned words in a small
//   FIFO that feeds the decoder over valid/ready.
//   Ports:
//     clk  : clock, all logic on posedge
//     rst  : synchronous active-low reset (0 = reset)
//     bus  : instr_fetch_if.master
//            imem_rd_en/imem_addr/imem_rdata   program memory read port
//            redirect_valid/redirect_pc        branch/jump target load
//            instr_valid/instr_ready/instr_data/instr_pc   decoder stream
//            halted                            fetch stopped on a halt opcode
//   Build option:
//     FETCH_HALT_DETECT_EN : a pushed word with opcode OPC_HALT stops further
//     reads and enters HALT until the next redirect. Without it halted is
//     tied 0 and fetch runs and wraps forever.
// -----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  fetch_entry_t      last_q, last_d;

  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              halt_seen;
  logic              issue;
  logic [CNT_W:0]    occ_after;

  always_comb begin
    fifo_valid = fifo_count != '0;
    pop        = fifo_valid && bus.instr_ready;

    // A response arriving during a redirect is killed: it belongs to the old path.
    push       = inflight_q && !bus.redirect_valid;
    push_entry = '{instr: bus.imem_rdata, pc: inflight_addr_q};

`ifdef FETCH_HALT_DETECT_EN
    // Combinational detection so no read is issued alongside the halt word.
    halt_seen = push && is_halt(bus.imem_rdata);
`else
    halt_seen = 1'b0;
`endif

    // Credit check: entries left after this cycle's pop plus the response
    // still on its way must leave room for one more read.
    occ_after = (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight_q);
    issue     = (state_q == RUN) && !bus.redirect_valid && !halt_seen
                && (occ_after < DEPTH_C);

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt_seen) state_d = HALT;
      HALT:    if (bus.redirect_valid) state_d = RUN;
      default: state_d = IDLE;
    endcase

    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = bus.redirect_pc;
    else if (issue)         pc_d = pc_q + 1'b1;

    inflight_d      = issue;
    inflight_addr_d = issue ? pc_q : inflight_addr_q;

    // Remember the last head shown so outputs hold when the FIFO drains.
    last_d = fifo_valid ? fifo_head : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      pc_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      last_q          <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      last_q          <= last_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.imem_rd_en  = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = fifo_valid;
  assign bus.instr_data  = fifo_valid ? fifo_head.instr : last_q.instr;
  assign bus.instr_pc    = fifo_valid ? fifo_head.pc    : last_q.pc;

`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted = (state_q == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule
